// File: rtl/wb_arbiter_3to2.sv
// Writeback arbiter: three buffered result sources drained onto two pregfile write ports
// under round-robin priority. Write enables double as issue-queue wakeups.

module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 70
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

module wb_arbiter_3to2 #(
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = 6,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [PREG_W-1:0] src0_pdst,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [PREG_W-1:0] src1_pdst,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              src2_valid,
  output logic              src2_ready,
  input  logic [PREG_W-1:0] src2_pdst,
  input  logic [DATA_W-1:0] src2_data,
  output logic              wren0,
  output logic [PREG_W-1:0] waddr0,
  output logic [DATA_W-1:0] wdata0,
  output logic              wren1,
  output logic [PREG_W-1:0] waddr1,
  output logic [DATA_W-1:0] wdata1
);
  localparam int NUM_SRC = 3;

  typedef struct packed {
    logic [PREG_W-1:0] pdst;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic    [NUM_SRC-1:0] valid, ready, full, empty, push, pop;
  wb_ent_t [NUM_SRC-1:0] din, head;
  logic    [1:0]         rr_ptr, scan_idx, g0_idx, g1_idx;
  logic                  g0_vld, g1_vld;

  assign valid  = {src2_valid, src1_valid, src0_valid};
  assign din[0] = '{pdst: src0_pdst, data: src0_data};
  assign din[1] = '{pdst: src1_pdst, data: src1_data};
  assign din[2] = '{pdst: src2_pdst, data: src2_data};

  // Ready comes from registered fullness only; pops in the same cycle grant no credit.
  assign ready = ~full & {NUM_SRC{~reset}};
  assign {src2_ready, src1_ready, src0_ready} = ready;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      // pdst 0 handshakes normally but is dropped before the FIFO.
      assign push[g] = valid[g] & ready[g] & (|din[g].pdst);
      wb_fifo #(.DEPTH(FIFO_DEPTH), .W(PREG_W + DATA_W)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .push (push[g]),
        .pop  (pop[g]),
        .din  (din[g]),
        .full (full[g]),
        .empty(empty[g]),
        .dout (head[g])
      );
    end
  endgenerate

  always_comb begin
    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = 2'd0;
    g1_idx   = 2'd0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!empty[scan_idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = scan_idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx;
        end
      end
      scan_idx = inc3(scan_idx);
    end
  end

  always_comb begin
    pop = '0;
    if (g0_vld) pop[g0_idx] = 1'b1;
    if (g1_vld) pop[g1_idx] = 1'b1;
  end

  assign wren0  = g0_vld;
  assign waddr0 = g0_vld ? head[g0_idx].pdst : '0;
  assign wdata0 = g0_vld ? head[g0_idx].data : '0;
  assign wren1  = g1_vld;
  assign waddr1 = g1_vld ? head[g1_idx].pdst : '0;
  assign wdata1 = g1_vld ? head[g1_idx].data : '0;

  // Priority restarts just past the last source that won a port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rr_ptr <= 2'd0;
    else if (flush)  rr_ptr <= rr_ptr;
    else if (g1_vld) rr_ptr <= inc3(g1_idx);
    else if (g0_vld) rr_ptr <= inc3(g0_idx);
  end
endmodule

// File: tb/tb_wb_arbiter_3to2.sv
// Directed bench for wb_arbiter_3to2: drives at negedge, checks port state at the following negedge.

module tb_wb_arbiter_3to2;
  logic        clk = 1'b0;
  logic        reset, flush;
  logic        src0_valid, src1_valid, src2_valid;
  logic        src0_ready, src1_ready, src2_ready;
  logic [5:0]  src0_pdst, src1_pdst, src2_pdst;
  logic [63:0] src0_data, src1_data, src2_data;
  logic        wren0, wren1;
  logic [5:0]  waddr0, waddr1;
  logic [63:0] wdata0, wdata1;

  int n_cmp = 0;
  int n_err = 0;

  logic [141:0] obs, exp_v;
  logic [2:0]   rdy;
  assign obs = {wren0, waddr0, wdata0, wren1, waddr1, wdata1};
  assign rdy = {src2_ready, src1_ready, src0_ready};

  localparam logic [70:0] IDLE = '0;

  always #5 clk = ~clk;

  wb_arbiter_3to2 dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_pdst(src0_pdst), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_pdst(src1_pdst), .src1_data(src1_data),
    .src2_valid(src2_valid), .src2_ready(src2_ready), .src2_pdst(src2_pdst), .src2_data(src2_data),
    .wren0(wren0), .waddr0(waddr0), .wdata0(wdata0),
    .wren1(wren1), .waddr1(waddr1), .wdata1(wdata1)
  );

  task automatic drive(input logic [2:0] v, input logic [5:0] p0, p1, p2);
    src0_valid = v[0]; src0_pdst = p0; src0_data = {58'd0, p0};
    src1_valid = v[1]; src1_pdst = p1; src1_data = {58'd0, p1};
    src2_valid = v[2]; src2_pdst = p2; src2_data = {58'd0, p2};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0;
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    drive(3'b111, 6'd9, 6'd9, 6'd9);
    #12;
    n_cmp++;
    if (obs !== {IDLE, IDLE}) begin n_err++; $display("FAIL reset_ports got=%h want=0", obs); end
    n_cmp++;
    if (rdy !== 3'b000) begin n_err++; $display("FAIL reset_ready got=%b want=000", rdy); end
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (rdy !== 3'b111) begin n_err++; $display("FAIL post_reset_ready got=%b want=111", rdy); end
  endtask

  task automatic test_single();
    do_reset();
    drive(3'b001, 6'd5, 6'd0, 6'd0);
    src0_data = 64'hA;
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    exp_v = {1'b1, 6'd5, 64'hA, IDLE};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL single_write got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE, IDLE}) begin n_err++; $display("FAIL single_idle got=%h want=0", obs); end
  endtask

  task automatic test_three_way();
    do_reset();
    drive(3'b111, 6'd1, 6'd2, 6'd3);
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    exp_v = {1'b1, 6'd1, 64'd1, 1'b1, 6'd2, 64'd2};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL three_c1 got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    exp_v = {1'b1, 6'd3, 64'd3, IDLE};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL three_c2 got=%h want=%h", obs, exp_v); end
    // rr_ptr is back at 0, so src1 must take port 0 ahead of src2.
    drive(3'b110, 6'd0, 6'd4, 6'd6);
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    exp_v = {1'b1, 6'd4, 64'd4, 1'b1, 6'd6, 64'd6};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL three_rr0 got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(3'b111, 6'd10, 6'd20, 6'd30);
    @(negedge clk);
    exp_v = {1'b1, 6'd10, 64'd10, 1'b1, 6'd20, 64'd20};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL sat_c1 got=%h want=%h", obs, exp_v); end
    drive(3'b111, 6'd11, 6'd21, 6'd31);
    @(negedge clk);
    n_cmp++;
    if (rdy !== 3'b011) begin n_err++; $display("FAIL sat_src2_full got=%b want=011", rdy); end
    exp_v = {1'b1, 6'd30, 64'd30, 1'b1, 6'd11, 64'd11};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL sat_c2 got=%h want=%h", obs, exp_v); end
    drive(3'b111, 6'd12, 6'd22, 6'd32);
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    n_cmp++;
    if (rdy !== 3'b101) begin n_err++; $display("FAIL sat_ready_c3 got=%b want=101", rdy); end
    exp_v = {1'b1, 6'd21, 64'd21, 1'b1, 6'd31, 64'd31};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL sat_c3 got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    exp_v = {1'b1, 6'd12, 64'd12, 1'b1, 6'd22, 64'd22};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL sat_c4 got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE, IDLE}) begin n_err++; $display("FAIL sat_idle got=%h want=0", obs); end
  endtask

  task automatic test_pdst_zero();
    do_reset();
    drive(3'b010, 6'd0, 6'd0, 6'd0);
    src1_data = 64'hFF;
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE, IDLE}) begin n_err++; $display("FAIL pz_c1 got=%h want=0", obs); end
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    n_cmp++;
    if (obs !== {IDLE, IDLE} || rdy !== 3'b111) begin
      n_err++; $display("FAIL pz_c2 got=%h rdy=%b want=0 rdy=111", obs, rdy);
    end
    drive(3'b010, 6'd0, 6'd7, 6'd0);
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    exp_v = {1'b1, 6'd7, 64'd7, IDLE};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL pz_after got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(3'b111, 6'd10, 6'd20, 6'd30);
    @(negedge clk);
    drive(3'b111, 6'd11, 6'd21, 6'd31);
    @(negedge clk);
    flush = 1'b1;
    drive(3'b001, 6'd40, 6'd0, 6'd0);
    #1;
    exp_v = {1'b1, 6'd30, 64'd30, 1'b1, 6'd11, 64'd11};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL flush_cycle got=%h want=%h", obs, exp_v); end
    @(negedge clk);
    flush = 1'b0;
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    n_cmp++;
    if (obs !== {IDLE, IDLE} || rdy !== 3'b111) begin
      n_err++; $display("FAIL flush_after got=%h rdy=%b want=0 rdy=111", obs, rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE, IDLE}) begin n_err++; $display("FAIL flush_dropped_push got=%h want=0", obs); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(3'b111, 6'd1, 6'd2, 6'd3);
    @(negedge clk);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    n_cmp++;
    if (wren0 !== 1'b1) begin n_err++; $display("FAIL ar_pre got=%b want=1", wren0); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== {IDLE, IDLE} || rdy !== 3'b000) begin
      n_err++; $display("FAIL ar_async got=%h rdy=%b want=0 rdy=000", obs, rdy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE, IDLE}) begin n_err++; $display("FAIL ar_stale1 got=%h want=0", obs); end
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE, IDLE}) begin n_err++; $display("FAIL ar_stale2 got=%h want=0", obs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_way();
    test_saturate();
    test_pdst_zero();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
